// File: rtl/sap1_datapath.sv
// SAP-1 datapath: executes the registered control word from the sequencer.
// Holds PC, MAR, program/data RAM, IR, A, B, the adder/subtractor and a
// sticky halt latch, and returns the IR opcode field to the sequencer.
// A side-band program port writes RAM independently of ctrl and halt.
module sap1_datapath #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [11:0]                ctrl,
  input  logic                       prog_we,
  input  logic [ADDR_W-1:0]          prog_addr,
  input  logic [DATA_W-1:0]          prog_data,
  output logic [DATA_W-ADDR_W-1:0]   opcode,
  output logic [DATA_W-1:0]          a_out,
  output logic [DATA_W-1:0]          bus_out,
  output logic                       carry,
  output logic                       zero,
  output logic                       halted,
  output logic                       bus_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Control word fields
  logic hlt, pc_inc, pc_en, mem_load, mem_en, ir_load, ir_en;
  logic a_load, a_en, b_load, adder_sub, adder_en;

  assign hlt       = ctrl[11];
  assign pc_inc    = ctrl[10];
  assign pc_en     = ctrl[9];
  assign mem_load  = ctrl[8];
  assign mem_en    = ctrl[7];
  assign ir_load   = ctrl[6];
  assign ir_en     = ctrl[5];
  assign a_load    = ctrl[4];
  assign a_en      = ctrl[3];
  assign b_load    = ctrl[2];
  assign adder_sub = ctrl[1];
  assign adder_en  = ctrl[0];

  // State registers
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Bus and adder nets
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum_full;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              adder_wins;
  logic [4:0]        drivers;

  // Adder/subtractor: subtraction is a + ~b + 1, cout=1 means no borrow
  always_comb begin
    b_op     = adder_sub ? ~b_q : b_q;
    sum_full = {1'b0, a_q} + {1'b0, b_op} + {{DATA_W{1'b0}}, adder_sub};
    sum      = sum_full[DATA_W-1:0];
    cout     = sum_full[DATA_W];
  end

  // Bus mux with fixed priority PC > MEM > IR > A > ADDER; idle bus reads 0
  always_comb begin
    bus = '0;
    if (pc_en)         bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    else if (mem_en)   bus = mem_q[mar_q];
    else if (ir_en)    bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
    else if (a_en)     bus = a_q;
    else if (adder_en) bus = sum;
  end

  // Conflict when two or more drivers are set: clearing the lowest set bit leaves a bit
  always_comb begin
    drivers      = {pc_en, mem_en, ir_en, a_en, adder_en};
    bus_conflict = |(drivers & (drivers - 5'd1));
    adder_wins   = adder_en & ~(pc_en | mem_en | ir_en | a_en);
  end

  // Next-state: every load samples the same pre-edge bus; nothing moves once halted
  always_comb begin
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (pc_inc)   pc_d  = pc_q + 1'b1;
      if (mem_load) mar_d = bus[ADDR_W-1:0];
      if (ir_load)  ir_d  = bus;
      if (a_load) begin
        a_d = bus;
        if (adder_wins) begin
          carry_d = cout;
          zero_d  = (sum == '0);
        end
      end
      if (b_load)   b_d      = bus;
      if (hlt)      halted_d = 1'b1;
    end
  end

  // Register file with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      mar_q    <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      mar_q    <= mar_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      halted_q <= halted_d;
    end
  end

  // RAM write from the program port; contents survive reset
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  assign opcode  = ir_q[DATA_W-1:ADDR_W];
  assign a_out   = a_q;
  assign bus_out = bus;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Bench for sap1_datapath: directed scenarios plus random control words,
// each checked against a behavioural model of the SAP-1 datapath.
module tb_sap1_datapath;

  logic        clk;
  logic        rst;
  logic [11:0] ctrl;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  a_out;
  logic [7:0]  bus_out;
  logic        carry;
  logic        zero;
  logic        halted;
  logic        bus_conflict;

  int n_pass  = 0;
  int n_total = 0;

  // Control word bits
  localparam logic [11:0] HLT = 12'h800, PCI = 12'h400, PCE = 12'h200, MLD = 12'h100;
  localparam logic [11:0] MEN = 12'h080, ILD = 12'h040, IEN = 12'h020, ALD = 12'h010;
  localparam logic [11:0] AEN = 12'h008, BLD = 12'h004, SUB = 12'h002, ADE = 12'h001;

  sap1_datapath #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .opcode(opcode), .a_out(a_out), .bus_out(bus_out),
    .carry(carry), .zero(zero), .halted(halted), .bus_conflict(bus_conflict)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of the architectural state
  logic [7:0] m_ram [16];
  int m_pc, m_mar, m_ir, m_a, m_b;
  bit m_c, m_z, m_halt;

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
    m_c = 0; m_z = 0; m_halt = 0;
  endtask

  function automatic int model_sum(logic [11:0] c, output bit cout);
    int r;
    if (c[1]) begin
      r = m_a - m_b;
      cout = (m_a >= m_b);
    end else begin
      r = m_a + m_b;
      cout = (r > 255);
    end
    return r & 255;
  endfunction

  function automatic int model_bus(logic [11:0] c);
    bit co;
    if (c[9]) return m_pc;
    if (c[7]) return int'(m_ram[m_mar]);
    if (c[5]) return m_ir % 16;
    if (c[3]) return m_a;
    if (c[0]) return model_sum(c, co);
    return 0;
  endfunction

  function automatic bit model_conflict(logic [11:0] c);
    int n;
    n = int'(c[9]) + int'(c[7]) + int'(c[5]) + int'(c[3]) + int'(c[0]);
    return n > 1;
  endfunction

  task automatic model_edge(logic [11:0] c, bit we, int addr, int data);
    int bus, s;
    bit co, adder_only;
    bus = model_bus(c);
    s = model_sum(c, co);
    adder_only = c[0] && !(c[9] || c[7] || c[5] || c[3]);
    if (!m_halt) begin
      if (c[10]) m_pc = (m_pc + 1) % 16;
      if (c[8])  m_mar = bus % 16;
      if (c[6])  m_ir = bus;
      if (c[4]) begin
        m_a = bus;
        if (adder_only) begin
          m_c = co;
          m_z = (s == 0);
        end
      end
      if (c[2])  m_b = bus;
      if (c[11]) m_halt = 1;
    end
    if (we) m_ram[addr] = data[7:0];
  endtask

  // Driver: one clock cycle with ctrl and optional program write.
  // Called and returning at posedge+1; checks bus before the edge and state after.
  task automatic step(logic [11:0] c, bit we = 0, int addr = 0, int data = 0);
    logic [7:0] eb;
    logic [12:0] es, os;
    ctrl = c; prog_we = we; prog_addr = addr[3:0]; prog_data = data[7:0];
    #1;
    eb = model_bus(c);
    n_total++;
    if (bus_out !== eb) $display("FAIL bus ctrl=%h got %h exp %h", c, bus_out, eb);
    else n_pass++;
    n_total++;
    if (bus_conflict !== model_conflict(c))
      $display("FAIL bus_conflict ctrl=%h got %b exp %b", c, bus_conflict, model_conflict(c));
    else n_pass++;
    model_edge(c, we, addr, data);
    @(posedge clk); #1;
    ctrl = '0; prog_we = 1'b0;
    es = {m_a[7:0], m_c, m_z, m_halt, m_ir[7:4]};
    os = {a_out, carry, zero, halted, opcode};
    n_total++;
    if (os !== es) $display("FAIL state ctrl=%h got a/c/z/h/op=%h exp %h", c, os, es);
    else n_pass++;
  endtask

  // Synchronise a reset pulse (RAM untouched)
  task automatic pulse_reset();
    rst = 1'b0; #2;
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Run one instruction through its fetch/execute T-states (up to nt of them)
  task automatic exec_instr(int op, int nt);
    logic [11:0] t [6];
    t[0] = PCE | MLD; t[1] = PCI; t[2] = MEN | ILD;
    case (op)
      0: begin t[3] = IEN | MLD; t[4] = MEN | ALD; t[5] = 12'h000; end
      1: begin t[3] = IEN | MLD; t[4] = MEN | BLD; t[5] = ADE | ALD; end
      2: begin t[3] = IEN | MLD; t[4] = MEN | BLD; t[5] = SUB | ADE | ALD; end
      default: begin t[3] = HLT; t[4] = 12'h000; t[5] = 12'h000; end
    endcase
    for (int i = 0; i < nt; i++) step(t[i]);
  endtask

  task automatic load_program();
    int addrs [7] = '{0, 1, 2, 3, 9, 10, 11};
    int vals  [7] = '{8'h09, 8'h1A, 8'h2B, 8'hF0, 8'h05, 8'h03, 8'h02};
    for (int i = 0; i < 16; i++) step(12'h000, 1, i, 0);
    for (int i = 0; i < 7; i++) step(12'h000, 1, addrs[i], vals[i]);
  endtask

  task automatic test_reset();
    rst = 1'b0; ctrl = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    model_reset();
    #3;
    n_total++;
    if ({a_out, carry, zero, halted, opcode} !== 13'h0)
      $display("FAIL reset_state got %h exp 0", {a_out, carry, zero, halted, opcode});
    else n_pass++;
    ctrl = PCE; #1;
    n_total++;
    if (bus_out !== 8'h00) $display("FAIL reset_pc got %h exp 00", bus_out);
    else n_pass++;
    ctrl = ADE; #1;
    n_total++;
    if (bus_out !== 8'h00) $display("FAIL reset_ab got %h exp 00", bus_out);
    else n_pass++;
    ctrl = '0; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_program();
    load_program();
    pulse_reset();
    exec_instr(0, 6); exec_instr(1, 6); exec_instr(2, 6); exec_instr(3, 6);
    ctrl = PCE; #1;
    n_total++;
    if ({a_out, halted, opcode, bus_out, carry, zero} !== {8'h06, 1'b1, 4'hF, 8'h04, 1'b1, 1'b0})
      $display("FAIL program a=%h h=%b op=%h pc=%h c=%b z=%b exp a=06 h=1 op=f pc=04 c=1 z=0",
               a_out, halted, opcode, bus_out, carry, zero);
    else n_pass++;
    ctrl = '0;
  endtask

  task automatic test_adder_flags();
    pulse_reset();
    step(12'h000, 1, 0, 8'h01);
    step(MEN | BLD);
    step(12'h000, 1, 0, 8'hFF);
    step(MEN | ALD);
    step(ADE | ALD);
    n_total++;
    if ({a_out, carry, zero} !== {8'h00, 1'b1, 1'b1})
      $display("FAIL add_wrap a=%h c=%b z=%b exp a=00 c=1 z=1", a_out, carry, zero);
    else n_pass++;
    step(SUB | ADE | ALD);
    n_total++;
    if ({a_out, carry, zero} !== {8'hFF, 1'b0, 1'b0})
      $display("FAIL sub_borrow a=%h c=%b z=%b exp a=ff c=0 z=0", a_out, carry, zero);
    else n_pass++;
  endtask

  task automatic test_pc_wrap_halt();
    pulse_reset();
    for (int i = 0; i < 17; i++) step(PCI);
    ctrl = PCE; #1;
    n_total++;
    if (bus_out !== 8'h01) $display("FAIL pc_wrap got %h exp 01", bus_out);
    else n_pass++;
    step(HLT | PCI);
    ctrl = PCE; #1;
    n_total++;
    if ({bus_out, halted} !== {8'h02, 1'b1})
      $display("FAIL halt_same_edge pc=%h h=%b exp pc=02 h=1", bus_out, halted);
    else n_pass++;
    step(PCI);
    ctrl = PCE; #1;
    n_total++;
    if (bus_out !== 8'h02) $display("FAIL halt_freeze got %h exp 02", bus_out);
    else n_pass++;
    ctrl = '0;
  endtask

  task automatic test_conflict();
    pulse_reset();
    step(12'h000, 1, 0, 8'h77);
    step(MEN | ALD);
    for (int i = 0; i < 3; i++) step(PCI);
    ctrl = PCE | AEN | BLD; #1;
    n_total++;
    if ({bus_out, bus_conflict} !== {8'h03, 1'b1})
      $display("FAIL conflict bus=%h conf=%b exp bus=03 conf=1", bus_out, bus_conflict);
    else n_pass++;
    step(PCE | AEN | BLD);
    ctrl = ADE; #1;
    n_total++;
    if (bus_out !== 8'h7A) $display("FAIL conflict_b sum=%h exp 7a", bus_out);
    else n_pass++;
    ctrl = '0;
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    step(12'h000, 1, 5, 8'h11);
    step(12'h000, 1, 0, 8'h05);
    step(MEN | MLD);
    ctrl = MEN | BLD; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 8'h22; #1;
    n_total++;
    if (bus_out !== 8'h11) $display("FAIL rw_same_addr got %h exp 11", bus_out);
    else n_pass++;
    step(MEN | BLD, 1, 5, 8'h22);
    ctrl = ADE; #1;
    n_total++;
    if (bus_out !== 8'h11) $display("FAIL rw_b got %h exp 11", bus_out);
    else n_pass++;
    ctrl = MEN; #1;
    n_total++;
    if (bus_out !== 8'h22) $display("FAIL rw_new_word got %h exp 22", bus_out);
    else n_pass++;
    ctrl = '0;
  endtask

  task automatic test_async_reset();
    load_program();
    pulse_reset();
    exec_instr(0, 6);
    exec_instr(1, 5);
    #2 rst = 1'b0;
    #1;
    n_total++;
    if ({a_out, carry, zero, halted, opcode} !== 13'h0)
      $display("FAIL async_reset got %h exp 0", {a_out, carry, zero, halted, opcode});
    else n_pass++;
    ctrl = PCE; #1;
    n_total++;
    if (bus_out !== 8'h00) $display("FAIL async_reset_pc got %h exp 00", bus_out);
    else n_pass++;
    ctrl = MEN; #1;
    n_total++;
    if (bus_out !== 8'h09) $display("FAIL async_reset_ram got %h exp 09", bus_out);
    else n_pass++;
    ctrl = '0;
    model_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    exec_instr(0, 6); exec_instr(1, 6); exec_instr(2, 6); exec_instr(3, 6);
    n_total++;
    if ({a_out, halted} !== {8'h06, 1'b1})
      $display("FAIL restart a=%h h=%b exp a=06 h=1", a_out, halted);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [11:0] c;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halt && $urandom_range(0, 5) == 0) pulse_reset();
      c = 12'($urandom) & 12'h7FF;
      if ($urandom_range(0, 39) == 0) c[11] = 1'b1;
      step(c, $urandom_range(0, 3) == 0, $urandom_range(0, 15), $urandom_range(0, 255));
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_adder_flags();
    test_pc_wrap_halt();
    test_conflict();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sap1_datapath.md
Name: sap1_datapath

Overview:
- Execution end of the SAP-1 control-word interface. Consumes the registered 12-bit control word from the sequencer and performs the bus transfers it encodes.
- Contains PC, MAR, program/data RAM, IR, accumulator A, operand register B, adder/subtractor and a sticky halt latch. Returns the opcode to the sequencer.
- Also provides a side-band RAM program port for bench and boot loading.

Parameters:
- ADDR_W, 4, width of PC, MAR and IR operand field; RAM depth is 2**ADDR_W.
- DATA_W, 8, width of bus, RAM words, IR, A and B. Opcode width is DATA_W-ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ctrl  in  12  control word: [11] HLT, [10] PC_INC, [9] PC_EN, [8] MEM_LOAD, [7] MEM_EN, [6] IR_LOAD, [5] IR_EN, [4] A_LOAD, [3] A_EN, [2] B_LOAD, [1] ADDER_SUB, [0] ADDER_EN
- prog_we  in  1  RAM write strobe from the program port
- prog_addr  in  ADDR_W  program-port address
- prog_data  in  DATA_W  program-port data
- opcode  out  DATA_W-ADDR_W  ir[DATA_W-1:ADDR_W], to sequencer
- a_out  out  DATA_W  accumulator value
- bus_out  out  DATA_W  current bus value (combinational, debug)
- carry  out  1  registered carry/no-borrow of last adder write to A
- zero  out  1  registered (result==0) of last adder write to A
- halted  out  1  sticky halt
- bus_conflict  out  1  combinational; high when more than one of bits 9,7,5,3,0 is set

Behaviour:
- Reset (rst=0, async): pc, mar, ir, a, b, carry, zero and halted all go to 0. RAM contents are not reset.
- Bus (combinational):
  - Driver priority is PC_EN > MEM_EN > IR_EN > A_EN > ADDER_EN.
  - PC_EN drives pc, zero-extended. MEM_EN drives ram[mar]. IR_EN drives ir[ADDR_W-1:0], zero-extended. A_EN drives a. ADDER_EN drives sum.
  - With no driver the bus is 0.
  - When more than one driver is set, the highest-priority driver wins and bus_conflict=1.
- Adder (combinational):
  - ADDER_SUB=0: sum = a + b.
  - ADDER_SUB=1: sum = a + ~b + 1.
  - Result is DATA_W bits with wrap. cout is the bit DATA_W carry-out; for subtraction cout=1 means no borrow.
- All register updates are at posedge clk and are applied only when halted=0:
  - PC_INC: pc <= pc+1, wrapping 2**ADDR_W-1 to 0.
  - MEM_LOAD: mar <= bus[ADDR_W-1:0].
  - IR_LOAD: ir <= bus.
  - A_LOAD: a <= bus. If ADDER_EN is also set and is the winning driver, carry <= cout and zero <= (sum==0) on the same edge. Otherwise carry and zero hold.
  - B_LOAD: b <= bus.
  - HLT: halted <= 1.
- Several load bits in one word all capture the same pre-edge bus value. A register may load while it is driving the bus (e.g. A_EN+A_LOAD is a no-op hold).
- HLT together with other bits in the same word: the other loads still take effect on that edge. From the next edge on, all ctrl bits are ignored until reset.
- Program port:
  - prog_we writes ram[prog_addr] <= prog_data at posedge.
  - It is independent of ctrl and of halted.
- RAM read is asynchronous. When prog_we and MEM_EN target the same address in the same cycle, the bus carries the old word and the new word is visible next cycle.
- Latency: each control word is fully applied at the single edge it is presented on. Opcode reflects the new ir one edge after IR_LOAD.
- Reset deasserted mid-program: execution restarts from pc=0 with RAM intact.

Test Plan:
- Load RAM {0:0x09, 1:0x1A, 2:0x2B, 3:0xF0, 9:0x05, 10:0x03, 11:0x02}. Drive the 6-step fetch/execute ctrl sequence for LDA, ADD, SUB, HLT. Required: a_out=0x06, halted=1, opcode=0xF, pc=4, carry=1, zero=0.
- A=0xFF, B=0x01, ctrl ADDER_EN|A_LOAD -> a=0x00, carry=1, zero=1. Then A=0x00, B=0x01, ctrl ADDER_SUB|ADDER_EN|A_LOAD -> a=0xFF, carry=0, zero=0.
- 17 consecutive PC_INC from reset -> pc reads 0x1 via PC_EN (wrap at 15 to 0). Then assert HLT|PC_INC -> pc=2 and halted=1; a further PC_INC -> pc stays 2.
- ctrl PC_EN|A_EN with pc=3, a=0x77, plus B_LOAD -> bus_out=0x03, bus_conflict=1, b=0x03.
- ram[5]=0x11, mar=5; prog_we to addr 5 with 0x22 together with MEM_EN|B_LOAD -> b=0x11; next cycle MEM_EN -> bus_out=0x22.
- Assert rst low asynchronously mid-cycle during an ADD sequence -> all registers and flags read 0 immediately, without waiting for a clock edge; RAM still holds the program.
